// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input mapper: joystick/key-state bit
// layout, rotation modes, coin stretcher states and the fixed PS/2 key map.
package arcade_input_pkg;

    localparam int J_RIGHT = 0;
    localparam int J_LEFT  = 1;
    localparam int J_DOWN  = 2;
    localparam int J_UP    = 3;
    localparam int J_BTN0  = 4;

    // Decoder slot layout; independent of BUTTONS
    localparam int S_RIGHT = 0;
    localparam int S_LEFT  = 1;
    localparam int S_DOWN  = 2;
    localparam int S_UP    = 3;
    localparam int S_BTN0  = 4;
    localparam int S_START = 8;
    localparam int S_COIN  = 9;
    localparam int NSLOT   = 10;

    typedef enum logic [1:0] {
        ROT_NONE     = 2'b00,
        ROT_CCW      = 2'b01,
        ROT_CW       = 2'b10,
        ROT_NONE_ALT = 2'b11
    } rotate_t;

    typedef enum logic [1:0] {
        CS_IDLE,
        CS_PULSE,
        CS_WAIT_REL
    } coin_state_t;

    localparam logic [7:0] KC_ARR_UP    = 8'h75;
    localparam logic [7:0] KC_ARR_DOWN  = 8'h72;
    localparam logic [7:0] KC_ARR_LEFT  = 8'h6B;
    localparam logic [7:0] KC_ARR_RIGHT = 8'h74;

    localparam logic [8:0] KC_P2_UP    = 9'h02D;
    localparam logic [8:0] KC_P2_DOWN  = 9'h02B;
    localparam logic [8:0] KC_P2_LEFT  = 9'h023;
    localparam logic [8:0] KC_P2_RIGHT = 9'h034;

    localparam logic [3:0][8:0] KC_P1_BTN =
        {9'h012, 9'h029, 9'h011, 9'h014};
    localparam logic [3:0][8:0] KC_P2_BTN =
        {9'h01D, 9'h015, 9'h01B, 9'h01C};
    localparam logic [3:0][8:0] KC_START =
        {9'h025, 9'h026, 9'h01E, 9'h016};
    localparam logic [3:0][8:0] KC_COIN =
        {9'h03E, 9'h03D, 9'h036, 9'h02E};

    localparam logic [8:0] KC_F1    = 9'h005;
    localparam logic [8:0] KC_F2    = 9'h006;
    localparam logic [8:0] KC_TEST  = 9'h02C;
    localparam logic [8:0] KC_PAUSE = 9'h04D;

    function automatic logic [NSLOT-1:0] key_slot(
        input logic [1:0] p,
        input logic [8:0] c
    );
        logic [NSLOT-1:0] h;
        h = '0;
        unique case (p)
            2'd0: begin
                h[S_RIGHT] = (c[7:0] == KC_ARR_RIGHT);
                h[S_LEFT]  = (c[7:0] == KC_ARR_LEFT);
                h[S_DOWN]  = (c[7:0] == KC_ARR_DOWN);
                h[S_UP]    = (c[7:0] == KC_ARR_UP);
                for (int b = 0; b < 4; b++)
                    h[S_BTN0+b] = (c == KC_P1_BTN[b]);
                h[S_START] = (c == KC_START[0]) || (c == KC_F1);
            end
            2'd1: begin
                h[S_RIGHT] = (c == KC_P2_RIGHT);
                h[S_LEFT]  = (c == KC_P2_LEFT);
                h[S_DOWN]  = (c == KC_P2_DOWN);
                h[S_UP]    = (c == KC_P2_UP);
                for (int b = 0; b < 4; b++)
                    h[S_BTN0+b] = (c == KC_P2_BTN[b]);
                h[S_START] = (c == KC_START[1]) || (c == KC_F2);
            end
            default: h[S_START] = (c == KC_START[p]);
        endcase
        h[S_COIN] = (c == KC_COIN[p]);
        return h;
    endfunction

endpackage

// File: rtl/coin_stretch.sv
// Per-player coin pulse stretcher: one fixed-width active-low pulse per
// press; a coin held through reset must be released before it counts.
module coin_stretch
    import arcade_input_pkg::*;
#(
    parameter int COIN_CYCLES = 400000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic raw,
    output logic coin_n
);

    localparam int CW = $clog2(COIN_CYCLES + 1);

    coin_state_t   st_q;
    logic [CW-1:0] cnt_q;
    logic          raw_q;
    logic          coin_n_q;

    // raw_q resets high so a held coin cannot look like a fresh edge
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            st_q     <= CS_IDLE;
            cnt_q    <= '0;
            raw_q    <= 1'b1;
            coin_n_q <= 1'b1;
        end else begin
            raw_q <= raw;
            unique case (st_q)
                CS_IDLE: begin
                    if (raw && !raw_q) begin
                        st_q     <= CS_PULSE;
                        cnt_q    <= CW'(COIN_CYCLES - 1);
                        coin_n_q <= 1'b0;
                    end
                end
                CS_PULSE: begin
                    if (cnt_q == '0) begin
                        st_q     <= CS_WAIT_REL;
                        coin_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                CS_WAIT_REL: begin
                    if (!raw)
                        st_q <= CS_IDLE;
                end
                default: st_q <= CS_IDLE;
            endcase
        end
    end

    assign coin_n = coin_n_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Player input front end: PS/2 key decode merged with hps_io joysticks,
// rotation remap, SOCD cancel, coin stretch, registered active-low outputs.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int PLAYERS     = 2,
    parameter int BUTTONS     = 2,
    parameter int COIN_CYCLES = 400000,
    parameter int SOCD_CANCEL = 1
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [10:0]                ps2_key,
    input  logic [16*PLAYERS-1:0]      joystick,
    input  logic [1:0]                 rotate,
    output logic [PLAYERS-1:0]         up_n,
    output logic [PLAYERS-1:0]         down_n,
    output logic [PLAYERS-1:0]         left_n,
    output logic [PLAYERS-1:0]         right_n,
    output logic [BUTTONS*PLAYERS-1:0] btn_n,
    output logic [PLAYERS-1:0]         start_n,
    output logic [PLAYERS-1:0]         coin_n,
    output logic                       test_n,
    output logic                       pause
);

    // Key state shares the joystick bit layout for a plain OR merge
    localparam int KS_START = J_BTN0 + BUTTONS;
    localparam int KS_COIN  = J_BTN0 + BUTTONS + 1;
    localparam int KS_W     = J_BTN0 + BUTTONS + 2;

    logic [10:0] ps2_q;
    logic        tog_prev_q;
    logic        primed_q;
    logic        ev;
    logic [8:0]  ev_code;
    logic        ev_make;

    logic [PLAYERS-1:0][KS_W-1:0] kst_q, kst_d;
    logic                         test_q, test_d;
    logic                         pause_st_q, pause_st_d;
    logic [NSLOT-1:0]             hit;

    logic [PLAYERS-1:0]         up_q, up_d;
    logic [PLAYERS-1:0]         down_q, down_d;
    logic [PLAYERS-1:0]         left_q, left_d;
    logic [PLAYERS-1:0]         right_q, right_d;
    logic [BUTTONS*PLAYERS-1:0] btn_q, btn_d;
    logic [PLAYERS-1:0]         start_q, start_d;
    logic                       test_n_q;
    logic                       pause_q;
    logic [PLAYERS-1:0]         coin_raw;

    logic [KS_W-1:0] raw;
    logic            ru, rd, rl, rr;
    logic            u, d, l, r;
    logic            unused_joy;

    assign unused_joy = ^joystick;

    assign ev      = primed_q && (ps2_q[10] != tog_prev_q);
    assign ev_make = ps2_q[9];
    assign ev_code = ps2_q[8:0];

    always_comb begin
        kst_d      = kst_q;
        test_d     = test_q;
        pause_st_d = pause_st_q;
        hit        = '0;
        if (ev) begin
            for (int p = 0; p < PLAYERS; p++) begin
                hit = key_slot(2'(p), ev_code);
                for (int s = 0; s < NSLOT; s++) begin
                    if (hit[s]) begin
                        if (s < S_BTN0)
                            kst_d[p][s] = ev_make;
                        else if (s == S_START)
                            kst_d[p][KS_START] = ev_make;
                        else if (s == S_COIN)
                            kst_d[p][KS_COIN] = ev_make;
                        else if (s - S_BTN0 < BUTTONS)
                            kst_d[p][s] = ev_make;
                    end
                end
            end
            if (ev_code == KC_TEST)
                test_d = ev_make;
            if (ev_code == KC_PAUSE && ev_make)
                pause_st_d = ~pause_st_q;
        end
    end

    always_comb begin
        up_d     = '1;
        down_d   = '1;
        left_d   = '1;
        right_d  = '1;
        btn_d    = '1;
        start_d  = '1;
        coin_raw = '0;
        raw      = '0;
        {ru, rd, rl, rr} = 4'b0;
        {u, d, l, r}     = 4'b0;
        for (int p = 0; p < PLAYERS; p++) begin
            raw = kst_q[p] | joystick[16*p +: KS_W];
            ru  = raw[J_UP];
            rd  = raw[J_DOWN];
            rl  = raw[J_LEFT];
            rr  = raw[J_RIGHT];
            unique case (rotate_t'(rotate))
                ROT_CCW: {u, d, l, r} = {rl, rr, rd, ru};
                ROT_CW:  {u, d, l, r} = {rr, rl, ru, rd};
                default: {u, d, l, r} = {ru, rd, rl, rr};
            endcase
            if (SOCD_CANCEL != 0) begin
                if (u && d) {u, d} = 2'b00;
                if (l && r) {l, r} = 2'b00;
            end
            up_d[p]    = ~u;
            down_d[p]  = ~d;
            left_d[p]  = ~l;
            right_d[p] = ~r;
            btn_d[BUTTONS*p +: BUTTONS] = ~raw[J_BTN0 +: BUTTONS];
            start_d[p]  = ~raw[KS_START];
            coin_raw[p] = raw[KS_COIN];
        end
    end

    // First cycle after reset only seeds the toggle history
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ps2_q      <= '0;
            tog_prev_q <= 1'b0;
            primed_q   <= 1'b0;
            kst_q      <= '0;
            test_q     <= 1'b0;
            pause_st_q <= 1'b0;
            up_q       <= '1;
            down_q     <= '1;
            left_q     <= '1;
            right_q    <= '1;
            btn_q      <= '1;
            start_q    <= '1;
            test_n_q   <= 1'b1;
            pause_q    <= 1'b0;
        end else begin
            ps2_q      <= ps2_key;
            primed_q   <= 1'b1;
            tog_prev_q <= primed_q ? ps2_q[10] : ps2_key[10];
            kst_q      <= kst_d;
            test_q     <= test_d;
            pause_st_q <= pause_st_d;
            up_q       <= up_d;
            down_q     <= down_d;
            left_q     <= left_d;
            right_q    <= right_d;
            btn_q      <= btn_d;
            start_q    <= start_d;
            test_n_q   <= ~test_q;
            pause_q    <= pause_st_q;
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        coin_stretch #(
            .COIN_CYCLES(COIN_CYCLES)
        ) u_coin (
            .clk_sys(clk_sys),
            .reset_n(reset_n),
            .raw    (coin_raw[p]),
            .coin_n (coin_n[p])
        );
    end

    assign up_n    = up_q;
    assign down_n  = down_q;
    assign left_n  = left_q;
    assign right_n = right_q;
    assign btn_n   = btn_q;
    assign start_n = start_q;
    assign test_n  = test_n_q;
    assign pause   = pause_q;

endmodule
